// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV opcodes for loads and stores
//   - funct3 codes for every load/store width
//   - exc_e  : fault code reported on wb_exc
//   - state_e: load/store FSM states
//   - f3_legal(): funct3 legality check for the configured XLEN
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_ILLEGAL  = 2'd2,
    EXC_TIMEOUT  = 2'd3
  } exc_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // rv64 enables the doubleword forms (LD/SD) and LWU.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3,
                                    input logic rv64);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) || (rv64 && (f3 == F3_SD));
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) ||
           (f3 == F3_LHU) || (rv64 && ((f3 == F3_LD) || (f3 == F3_LWU)));
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   funct3_i   : access width (bits 1:0) and load signedness (bit 2)
//   offset_i   : byte offset of the access within the XLEN-wide word
//   rs2_i      : raw store data
//   rdata_i    : full memory read word
//   be_o       : byte enables (size mask shifted to the offset)
//   wdata_o    : store data replicated across every lane
//   load_o     : extracted and sign/zero-extended load result
//   misalign_o : access is not naturally aligned for its width
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                    funct3_i,
  input  logic [$clog2(XLEN/8)-1:0]     offset_i,
  input  logic [XLEN-1:0]               rs2_i,
  input  logic [XLEN-1:0]               rdata_i,
  output logic [XLEN/8-1:0]             be_o,
  output logic [XLEN-1:0]               wdata_o,
  output logic [XLEN-1:0]               load_o,
  output logic                          misalign_o
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] shifted;

  always_comb begin
    size_mask  = '0;
    wdata_o    = '0;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'd0: begin
        size_mask = NB'(1);
        wdata_o   = {NB{rs2_i[7:0]}};
      end
      2'd1: begin
        size_mask  = NB'(3);
        wdata_o    = {(NB/2){rs2_i[15:0]}};
        misalign_o = offset_i[0];
      end
      2'd2: begin
        size_mask  = NB'(15);
        wdata_o    = {(NB/4){rs2_i[31:0]}};
        misalign_o = |offset_i[1:0];
      end
      default: begin
        size_mask  = '1;
        wdata_o    = rs2_i;
        misalign_o = |offset_i;
      end
    endcase
  end

  assign be_o    = size_mask << offset_i;
  // Bring the addressed lane down to bit 0 before extension.
  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_LB:   load_o = XLEN'($signed(shifted[7:0]));
      F3_LH:   load_o = XLEN'($signed(shifted[15:0]));
      F3_LW:   load_o = XLEN'($signed(shifted[31:0]));
      F3_LBU:  load_o = XLEN'(shifted[7:0]);
      F3_LHU:  load_o = XLEN'(shifted[15:0]);
      F3_LWU:  load_o = XLEN'(shifted[31:0]);
      default: load_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: stall-capable memory-access stage between EX/MEM and MEM/WB.
// Issues one req/ack data-memory transaction per legal, aligned load or store,
// flags misaligned / illegal-funct3 / bus-timeout faults, and registers WB.
//   ex_*   : instruction handoff from EX (valid/ready)
//   dmem_* : data-memory request channel (held stable while req is high)
//   wb_*   : registered retirement outputs, qualified by a one-cycle wb_valid_o
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for a new instruction; non-memory and faulting ops
//         | retire straight from here
// ST_BUSY | memory transaction in flight, waiting for ack or timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [31:0]          ex_pc_i,
  input  logic [31:0]          ex_ir_i,
  input  logic [XLEN-1:0]      ex_alu_out_i,
  input  logic [XLEN-1:0]      ex_rs2_data_i,
  input  logic                 ex_rd_we_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [XLEN/8-1:0]    dmem_be_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic                 wb_valid_o,
  output logic [31:0]          wb_pc_o,
  output logic [31:0]          wb_ir_o,
  output logic [XLEN-1:0]      wb_result_o,
  output logic [4:0]           wb_rd_o,
  output logic                 wb_we_o,
  output logic [1:0]           wb_exc_o
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [OW-1:0]     off_q, off_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_pc_q, wb_pc_d;
  logic [31:0]       wb_ir_q, wb_ir_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;
  logic              wb_we_q, wb_we_d;
  exc_e              wb_exc_q, wb_exc_d;

  logic              busy;
  logic              is_load, is_store, is_mem;
  logic              to_hit;
  logic [2:0]        al_f3;
  logic [OW-1:0]     al_off;
  logic [NB-1:0]     al_be;
  logic [XLEN-1:0]   al_wdata, al_load;
  logic              al_misalign;

  assign busy     = (state_q == ST_BUSY);
  assign is_load  = (ex_ir_i[6:0] == OPC_LOAD);
  assign is_store = (ex_ir_i[6:0] == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign to_hit   = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // wb_ir_q is loaded at acceptance, so while BUSY it still holds the
  // in-flight instruction and supplies the funct3 for load extraction.
  assign al_f3  = busy ? wb_ir_q[14:12] : ex_ir_i[14:12];
  assign al_off = busy ? off_q : ex_alu_out_i[OW-1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i   (al_f3),
    .offset_i   (al_off),
    .rs2_i      (ex_rs2_data_i),
    .rdata_i    (dmem_rdata_i),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .load_o     (al_load),
    .misalign_o (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    off_d       = off_q;
    wb_valid_d  = 1'b0;
    wb_pc_d     = wb_pc_q;
    wb_ir_d     = wb_ir_q;
    wb_result_d = wb_result_q;
    wb_we_d     = wb_we_q;
    wb_exc_d    = wb_exc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid_i) begin
          wb_pc_d     = ex_pc_i;
          wb_ir_d     = ex_ir_i;
          wb_result_d = ex_alu_out_i;
          wb_we_d     = 1'b0;
          wb_exc_d    = EXC_NONE;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = ex_rd_we_i;
          end else if (!f3_legal(is_store, ex_ir_i[14:12], XLEN == 64)) begin
            wb_valid_d = 1'b1;
            wb_exc_d   = EXC_ILLEGAL;
          end else if (al_misalign) begin
            wb_valid_d = 1'b1;
            wb_exc_d   = EXC_MISALIGN;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            addr_d  = {ex_alu_out_i[XLEN-1:OW], {OW{1'b0}}};
            be_d    = al_be;
            wdata_d = al_wdata;
            we_d    = is_store;
            off_d   = ex_alu_out_i[OW-1:0];
          end
        end
      end
      ST_BUSY: begin
        // Ack wins over a timeout landing in the same cycle.
        if (dmem_ack_i) begin
          state_d     = ST_IDLE;
          wb_valid_d  = 1'b1;
          wb_exc_d    = EXC_NONE;
          wb_result_d = we_q ? '0 : al_load;
          wb_we_d     = !we_q && (wb_ir_q[11:7] != 5'd0);
        end else if (to_hit) begin
          state_d     = ST_IDLE;
          wb_valid_d  = 1'b1;
          wb_exc_d    = EXC_TIMEOUT;
          wb_result_d = '0;
          wb_we_d     = 1'b0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_ir_q     <= '0;
      wb_result_q <= '0;
      wb_we_q     <= 1'b0;
      wb_exc_q    <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      off_q       <= off_d;
      wb_valid_q  <= wb_valid_d;
      wb_pc_q     <= wb_pc_d;
      wb_ir_q     <= wb_ir_d;
      wb_result_q <= wb_result_d;
      wb_we_q     <= wb_we_d;
      wb_exc_q    <= wb_exc_d;
    end
  end

  // req comes straight from the state register so an async reset drops it at once.
  assign ex_ready_o   = !busy;
  assign dmem_req_o   = busy;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_pc_o      = wb_pc_q;
  assign wb_ir_o      = wb_ir_q;
  assign wb_result_o  = wb_result_q;
  assign wb_rd_o      = wb_ir_q[11:7];
  assign wb_we_o      = wb_we_q;
  assign wb_exc_o     = wb_exc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit at XLEN=32, TIMEOUT=8. Expected WB records are
// queued when an instruction is driven and compared when wb_valid_o fires.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_ready_o, ex_rd_we_i;
  logic [31:0] ex_pc_i, ex_ir_i, ex_alu_out_i, ex_rs2_data_i;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        wb_valid_o, wb_we_o;
  logic [31:0] wb_pc_o, wb_ir_o, wb_result_o;
  logic [4:0]  wb_rd_o;
  logic [1:0]  wb_exc_o;

  load_store_unit #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_pc_i      (ex_pc_i),
    .ex_ir_i      (ex_ir_i),
    .ex_alu_out_i (ex_alu_out_i),
    .ex_rs2_data_i(ex_rs2_data_i),
    .ex_rd_we_i   (ex_rd_we_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_pc_o      (wb_pc_o),
    .wb_ir_o      (wb_ir_o),
    .wb_result_o  (wb_result_o),
    .wb_rd_o      (wb_rd_o),
    .wb_we_o      (wb_we_o),
    .wb_exc_o     (wb_exc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] res;
    logic        we;
    logic [1:0]  exc;
    bit          chk_res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ld(input logic [2:0] f3, input logic [4:0] rd);
    return {12'h000, 5'd1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_st(input logic [2:0] f3);
    return {7'h00, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
  endfunction

  task automatic push_exp(input logic [31:0] pc, ir, res, input logic we,
                          input logic [1:0] exc, input bit chk_res);
    exp_t e;
    e.pc = pc; e.ir = ir; e.res = res; e.we = we; e.exc = exc; e.chk_res = chk_res;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] pc, ir, alu, rs2, input logic rd_we);
    ex_pc_i = pc; ex_ir_i = ir; ex_alu_out_i = alu; ex_rs2_data_i = rs2;
    ex_rd_we_i = rd_we; ex_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ex_valid_i = 1'b0;
  endtask

  // Holds ack off for k-1 request cycles, then acks on the k-th.
  task automatic respond(input int k, input logic [31:0] rdata, exp_addr,
                         input logic [3:0] exp_be, input logic exp_we,
                         input logic [31:0] exp_wdata, input bit chk_wd);
    for (int i = 0; i < k; i++) begin
      chk("req_hi", dmem_req_o, 1'b1);
      chk("req_addr", dmem_addr_o, exp_addr);
      chk("req_be", dmem_be_o, exp_be);
      chk("req_we", dmem_we_o, exp_we);
      chk("req_ready_lo", ex_ready_o, 1'b0);
      if (chk_wd) chk("req_wdata", dmem_wdata_o, exp_wdata);
      if (i == k - 1) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
      end
      @(negedge clk);
    end
    dmem_ack_i = 1'b0;
    chk("ack_wb_valid", wb_valid_o, 1'b1);
    chk("ack_ready", ex_ready_o, 1'b1);
  endtask

  always @(negedge clk) begin
    if (wb_valid_o) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_pc", wb_pc_o, mon_e.pc);
        chk("wb_ir", wb_ir_o, mon_e.ir);
        chk("wb_rd", wb_rd_o, mon_e.ir[11:7]);
        chk("wb_we", wb_we_o, mon_e.we);
        chk("wb_exc", wb_exc_o, mon_e.exc);
        if (mon_e.chk_res) chk("wb_result", wb_result_o, mon_e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir;
    int          n;
    rst_n = 1'b0; ex_valid_i = 1'b0; ex_pc_i = '0; ex_ir_i = '0; ex_alu_out_i = '0;
    ex_rs2_data_i = '0; ex_rd_we_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    #12;
    chk("rst_ready", ex_ready_o, 1'b1);
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_be", dmem_be_o, 4'h0);
    chk("rst_result", wb_result_o, 32'h0);
    chk("rst_exc", wb_exc_o, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1, x0, 5
    push_exp(32'h100, 32'h00500093, 32'h5, 1'b1, 2'd0, 1'b1);
    issue(32'h100, 32'h00500093, 32'h5, 32'h0, 1'b1);
    chk("alu_latency", wb_valid_o, 1'b1);

    ir = mk_ld(3'b000, 5'd5);   // LB, zero-wait ack
    push_exp(32'h104, ir, 32'hFFFF_FF80, 1'b1, 2'd0, 1'b1);
    issue(32'h104, ir, 32'h1003, 32'h0, 1'b0);
    respond(1, 32'h8022_3344, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b0);

    ir = mk_ld(3'b100, 5'd6);   // LBU
    push_exp(32'h108, ir, 32'h0000_0080, 1'b1, 2'd0, 1'b1);
    issue(32'h108, ir, 32'h1003, 32'h0, 1'b0);
    respond(1, 32'h8022_3344, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b0);

    ir = mk_st(3'b001);         // SH
    push_exp(32'h10C, ir, 32'h0, 1'b0, 2'd0, 1'b0);
    issue(32'h10C, ir, 32'h2002, 32'h1234_ABCD, 1'b0);
    respond(1, 32'h0, 32'h2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b1);

    ir = mk_ld(3'b010, 5'd7);   // LW misaligned
    push_exp(32'h110, ir, 32'h0, 1'b0, 2'd1, 1'b0);
    issue(32'h110, ir, 32'h1002, 32'h0, 1'b0);
    chk("mis_no_req", dmem_req_o, 1'b0);
    chk("mis_latency", wb_valid_o, 1'b1);

    ir = mk_ld(3'b011, 5'd7);   // LD on RV32: illegal
    push_exp(32'h114, ir, 32'h0, 1'b0, 2'd2, 1'b0);
    issue(32'h114, ir, 32'h1000, 32'h0, 1'b0);
    chk("ill_no_req", dmem_req_o, 1'b0);
    chk("ill_latency", wb_valid_o, 1'b1);

    ir = mk_ld(3'b001, 5'd9);   // LH, ack after 3 request cycles
    push_exp(32'h118, ir, 32'hFFFF_8001, 1'b1, 2'd0, 1'b1);
    issue(32'h118, ir, 32'h3002, 32'h0, 1'b0);
    respond(3, 32'h8001_1234, 32'h3000, 4'b1100, 1'b0, 32'h0, 1'b0);

    ir = mk_ld(3'b101, 5'd10);  // LHU
    push_exp(32'h11C, ir, 32'h0000_F234, 1'b1, 2'd0, 1'b1);
    issue(32'h11C, ir, 32'h3000, 32'h0, 1'b0);
    respond(2, 32'h8001_F234, 32'h3000, 4'b0011, 1'b0, 32'h0, 1'b0);

    ir = mk_ld(3'b010, 5'd0);   // LW into x0: no register write
    push_exp(32'h120, ir, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b1);
    issue(32'h120, ir, 32'h3004, 32'h0, 1'b0);
    respond(1, 32'hDEAD_BEEF, 32'h3004, 4'b1111, 1'b0, 32'h0, 1'b0);

    ir = mk_st(3'b000);         // SB
    push_exp(32'h124, ir, 32'h0, 1'b0, 2'd0, 1'b0);
    issue(32'h124, ir, 32'h4001, 32'hCAFE_0077, 1'b0);
    respond(1, 32'h0, 32'h4000, 4'b0010, 1'b1, 32'h7777_7777, 1'b1);

    ir = mk_st(3'b010);         // SW
    push_exp(32'h128, ir, 32'h0, 1'b0, 2'd0, 1'b0);
    issue(32'h128, ir, 32'h4004, 32'h89AB_CDEF, 1'b0);
    respond(2, 32'h0, 32'h4004, 4'b1111, 1'b1, 32'h89AB_CDEF, 1'b1);

    // Ack with no request outstanding must be ignored.
    dmem_ack_i = 1'b1;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    chk("stray_ack_wb_valid", wb_valid_o, 1'b0);
    chk("stray_ack_ready", ex_ready_o, 1'b1);
    chk("stray_ack_req", dmem_req_o, 1'b0);

    ir = mk_ld(3'b010, 5'd3);   // LW never acked: timeout
    push_exp(32'h12C, ir, 32'h0, 1'b0, 2'd3, 1'b0);
    issue(32'h12C, ir, 32'h5000, 32'h0, 1'b0);
    n = 0;
    while (dmem_req_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, 8);
    chk("timeout_wb_valid", wb_valid_o, 1'b1);
    chk("timeout_ready", ex_ready_o, 1'b1);

    // Reset during BUSY abandons the transaction.
    ir = mk_ld(3'b010, 5'd4);
    issue(32'h130, ir, 32'h6000, 32'h0, 1'b0);
    chk("rb_req_before", dmem_req_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_req", dmem_req_o, 1'b0);
    chk("rb_wb_valid", wb_valid_o, 1'b0);
    chk("rb_wb_we", wb_we_o, 1'b0);
    chk("rb_wb_result", wb_result_o, 32'h0);
    chk("rb_wb_pc", wb_pc_o, 32'h0);
    chk("rb_ready", ex_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    push_exp(32'h200, 32'h00500093, 32'h5, 1'b1, 2'd0, 1'b1);
    issue(32'h200, 32'h00500093, 32'h5, 32'h0, 1'b1);
    chk("post_rst_latency", wb_valid_o, 1'b1);

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
